pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and sequencing controller for the five-stage pipeline. It drives the per-stage write enables (`pc_write`, `if_id_write`, `id_exe_write`, `exe_mem_write`, `mem_wb_write`) and the bubble/flush controls of the pipeline registers. It resolves three conditions:
- data-memory wait stalls;
- load-use hazards;
- taken-branch flushes.

It also guards the memory handshake with a timeout and keeps saturating stall and flush counters for bring-up.

## Interface
Parameters:
- `MEM_TIMEOUT`, 16: consecutive frozen cycles tolerated before error; legal range 2..255.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `id_rs`, `id_rt`  in  5 each  source register numbers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt`  in  1 each  the ID instruction reads that source.
- `ex_num_write`  in  5  destination register of the instruction in EX.
- `ex_mem_read`  in  1  the EX instruction is a load.
- `ex_reg_write`  in  1  the EX instruction writes the register file.
- `branch_taken`  in  1  branch/jump resolved taken in EX this cycle.
- `mem_req`  in  1  the MEM-stage instruction accesses data memory.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `cnt_clear`  in  1  synchronous clear of both counters.
- `pc_write`, `if_id_write`, `id_exe_write`, `exe_mem_write`, `mem_wb_write`  out  1 each  stage write enables.
- `if_id_flush`, `id_exe_flush`  out  1 each  load a bubble (32'h0000_0000 instruction, controls cleared); effective only when the matching write enable is 1.
- `mem_err`  out  1  memory timeout; sticky until reset.
- `ctrl_state`  out  2  RUN=0, WAIT=1, ERROR=2.
- `stall_cycles`  out  `CNT_W`  saturating count of stall cycles.
- `flush_events`  out  `CNT_W`  saturating count of branch flushes.

## Operation
Derived conditions:
- `freeze` = `mem_req` & ~`mem_ready`.
- `load_use` = `ex_mem_read` & `ex_reg_write` & (`ex_num_write` != 0) & ((`id_uses_rs` & `id_rs` == `ex_num_write`) | (`id_uses_rt` & `id_rt` == `ex_num_write`)).

Output priority, evaluated combinationally each cycle in RUN/WAIT:
1. **`freeze`**: all five enables 0, both flushes 0. The whole pipe holds, including a pending `branch_taken`, which re-presents next cycle.
2. **`branch_taken`**: all enables 1, `if_id_flush`=1, `id_exe_flush`=1. It overrides `load_use` because the ID instruction is squashed anyway.
3. **`load_use`**: `pc_write`=0, `if_id_write`=0, `id_exe_write`=1 with `id_exe_flush`=1, `exe_mem_write`=1, `mem_wb_write`=1.
4. **Otherwise**: all enables 1, flushes 0.

FSM:
- **RUN**: on `freeze`, go to WAIT with `wait_cnt`=1.
- **WAIT**:
  - on `freeze`, `wait_cnt`+1;
  - if `wait_cnt` reaches `MEM_TIMEOUT` while still frozen, go to ERROR;
  - on `mem_ready`, the pipe advances that same cycle, go to RUN, `wait_cnt`=0.
- **ERROR**: all enables 0, flushes 0, `mem_err`=1, counters frozen. Only `reset` exits.

Counters:
- `stall_cycles` increments on each cycle with `freeze` or (`load_use` & ~`branch_taken`) while in RUN/WAIT.
- `flush_events` increments on each non-frozen `branch_taken` cycle.
- Both saturate at all-ones and never wrap.
- `cnt_clear` has priority over increment: the counter is 0 next cycle.

## Timing
- **While `reset` is high**, and on its assertion regardless of clock: `ctrl_state`=RUN, `wait_cnt`=0, `mem_err`=0, counters 0, all enables forced 0, flushes 0.
- **First edge after reset release**: normal RUN decoding.
- **Enables and flushes**: zero latency (combinational from inputs and state); the pipeline registers act on them at the same edge.
- **Memory stall**: an N-cycle stall (N < `MEM_TIMEOUT`) freezes exactly N cycles and adds N to `stall_cycles`.
- **Timeout**: exactly `MEM_TIMEOUT` consecutive frozen cycles → `ctrl_state`=ERROR and `mem_err`=1 from the next cycle.
- **Load-use**: exactly 1 bubble cycle. The next cycle sees the load in MEM, so `load_use` is no longer true.
- **Reset mid-WAIT or mid-ERROR**: immediate return to the reset values.

## Test plan
- **Load-use**: `ex_mem_read`=1, `ex_reg_write`=1, `ex_num_write`=8, `id_rs`=8, `id_uses_rs`=1 → one cycle with `pc_write`=0, `if_id_write`=0, `id_exe_flush`=1; `stall_cycles` 0→1. Repeat with `ex_num_write`=0 → no stall.
- **Branch flush**: `branch_taken`=1 together with a load-use → `if_id_flush`=`id_exe_flush`=1, all enables 1, `flush_events`=1, `stall_cycles` unchanged.
- **Memory wait**: `mem_req`=1, `mem_ready`=0 for 3 cycles then 1, `MEM_TIMEOUT`=16, with `branch_taken` held → 3 cycles all enables 0 and `ctrl_state`=WAIT. On the 4th cycle enables are 1 with flushes 1, `ctrl_state` returns to RUN; `stall_cycles`=3, `flush_events`=1.
- **Timeout**: `MEM_TIMEOUT`=4, `mem_ready` held 0 → after 4 frozen cycles `ctrl_state`=2, `mem_err`=1, enables stay 0 even when `mem_ready` later rises. Asynchronous `reset` pulse between edges → immediate RUN, `mem_err`=0.
- **Saturation**: `CNT_W`=4, 20 stall cycles → `stall_cycles`=15 held. `cnt_clear` together with a stall → 0 next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and the hazard controller (slave).
// CNT_W must match the controller's counter width.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [4:0]       ex_num_write;
  logic             ex_mem_read;
  logic             ex_reg_write;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             cnt_clear;

  logic             pc_write;
  logic             if_id_write;
  logic             id_exe_write;
  logic             exe_mem_write;
  logic             mem_wb_write;
  logic             if_id_flush;
  logic             id_exe_flush;
  logic             mem_err;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_num_write, ex_mem_read,
           ex_reg_write, branch_taken, mem_req, mem_ready, cnt_clear,
    input  pc_write, if_id_write, id_exe_write, exe_mem_write, mem_wb_write,
           if_id_flush, id_exe_flush, mem_err, ctrl_state, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_num_write, ex_mem_read,
           ex_reg_write, branch_taken, mem_req, mem_ready, cnt_clear,
    output pc_write, if_id_write, id_exe_write, exe_mem_write, mem_wb_write,
           if_id_flush, id_exe_flush, mem_err, ctrl_state, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait freeze, load-use bubble,
// taken-branch flush, memory handshake timeout and saturating bring-up counters.
//
//   state | meaning
//   RUN   | normal decoding, no outstanding memory wait
//   WAIT  | data memory busy, counting consecutive frozen cycles
//   ERROR | memory timeout; pipe held until reset
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input logic               clock,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic freeze;
  logic rs_hit;
  logic rt_hit;
  logic load_use;
  logic active;

  assign freeze   = hz.mem_req & ~hz.mem_ready;
  assign rs_hit   = hz.id_uses_rs & (hz.id_rs == hz.ex_num_write);
  assign rt_hit   = hz.id_uses_rt & (hz.id_rt == hz.ex_num_write);
  assign load_use = hz.ex_mem_read & hz.ex_reg_write & (hz.ex_num_write != 5'd0)
                  & (rs_hit | rt_hit);
  assign active   = ~reset & (state_q != ST_ERROR);

  // Enables are combinational so the pipeline registers act on them at this same edge.
  always_comb begin
    hz.pc_write      = 1'b0;
    hz.if_id_write   = 1'b0;
    hz.id_exe_write  = 1'b0;
    hz.exe_mem_write = 1'b0;
    hz.mem_wb_write  = 1'b0;
    hz.if_id_flush   = 1'b0;
    hz.id_exe_flush  = 1'b0;
    if (active && !freeze) begin
      hz.id_exe_write  = 1'b1;
      hz.exe_mem_write = 1'b1;
      hz.mem_wb_write  = 1'b1;
      if (hz.branch_taken) begin
        hz.pc_write     = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.if_id_flush  = 1'b1;
        hz.id_exe_flush = 1'b1;
      end else if (load_use) begin
        hz.id_exe_flush = 1'b1;
      end else begin
        hz.pc_write    = 1'b1;
        hz.if_id_write = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    stall_d    = stall_q;
    flush_d    = flush_q;

    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      ST_WAIT: begin
        if (freeze) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q + 8'd1 == TIMEOUT) begin
            state_d   = ST_ERROR;
            mem_err_d = 1'b1;
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase

    // Counters hold entirely once the controller has given up on memory.
    if (state_q != ST_ERROR) begin
      if (hz.cnt_clear) begin
        stall_d = '0;
        flush_d = '0;
      end else begin
        if ((freeze || (load_use && !hz.branch_taken)) && stall_q != CNT_MAX)
          stall_d = stall_q + 1'b1;
        if (hz.branch_taken && !freeze && flush_q != CNT_MAX)
          flush_d = flush_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
      mem_err_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign hz.mem_err      = mem_err_q;
  assign hz.ctrl_state   = state_q;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_events = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Drives two controllers (timeout 16 / 16-bit counters and timeout 4 / 4-bit counters)
// with identical stimulus and checks both against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int TO_A = 16;
  localparam int W_A  = 16;
  localparam int TO_B = 4;
  localparam int W_B  = 4;

  logic       clock;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_num_write;
  logic       id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write;
  logic       branch_taken, mem_req, mem_ready, cnt_clear;

  pipe_hazard_ctrl_if #(.CNT_W(W_A)) ifa();
  pipe_hazard_ctrl_if #(.CNT_W(W_B)) ifb();

  assign ifa.id_rs = id_rs;               assign ifb.id_rs = id_rs;
  assign ifa.id_rt = id_rt;               assign ifb.id_rt = id_rt;
  assign ifa.id_uses_rs = id_uses_rs;     assign ifb.id_uses_rs = id_uses_rs;
  assign ifa.id_uses_rt = id_uses_rt;     assign ifb.id_uses_rt = id_uses_rt;
  assign ifa.ex_num_write = ex_num_write; assign ifb.ex_num_write = ex_num_write;
  assign ifa.ex_mem_read = ex_mem_read;   assign ifb.ex_mem_read = ex_mem_read;
  assign ifa.ex_reg_write = ex_reg_write; assign ifb.ex_reg_write = ex_reg_write;
  assign ifa.branch_taken = branch_taken; assign ifb.branch_taken = branch_taken;
  assign ifa.mem_req = mem_req;           assign ifb.mem_req = mem_req;
  assign ifa.mem_ready = mem_ready;       assign ifb.mem_ready = mem_ready;
  assign ifa.cnt_clear = cnt_clear;       assign ifb.cnt_clear = cnt_clear;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO_A), .CNT_W(W_A)) dut_a (
    .clock(clock), .reset(reset), .hz(ifa));
  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO_B), .CNT_W(W_B)) dut_b (
    .clock(clock), .reset(reset), .hz(ifb));

  // Observed outputs; enable order {pc, if_id, id_exe, exe_mem, mem_wb}, flush order {if_id, id_exe}.
  logic [4:0]  obs_en[2];
  logic [1:0]  obs_fl[2];
  logic [1:0]  obs_state[2];
  logic        obs_err[2];
  logic [15:0] obs_stall[2];
  logic [15:0] obs_flush[2];

  assign obs_en[0] = {ifa.pc_write, ifa.if_id_write, ifa.id_exe_write, ifa.exe_mem_write, ifa.mem_wb_write};
  assign obs_en[1] = {ifb.pc_write, ifb.if_id_write, ifb.id_exe_write, ifb.exe_mem_write, ifb.mem_wb_write};
  assign obs_fl[0] = {ifa.if_id_flush, ifa.id_exe_flush};
  assign obs_fl[1] = {ifb.if_id_flush, ifb.id_exe_flush};
  assign obs_state[0] = ifa.ctrl_state;
  assign obs_state[1] = ifb.ctrl_state;
  assign obs_err[0] = ifa.mem_err;
  assign obs_err[1] = ifb.mem_err;
  assign obs_stall[0] = ifa.stall_cycles;
  assign obs_stall[1] = {12'd0, ifb.stall_cycles};
  assign obs_flush[0] = ifa.flush_events;
  assign obs_flush[1] = {12'd0, ifb.flush_events};

  int vectors;
  int miscompares;

  // Reference model: state 0=RUN 1=WAIT 2=ERROR, consecutive frozen count, plain integer counters.
  int         m_state[2];
  int         m_frozen[2];
  int         m_stall[2];
  int         m_flush[2];
  logic [4:0] exp_en[2];
  logic [1:0] exp_fl[2];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int tmo(int i);
    return (i == 0) ? TO_A : TO_B;
  endfunction

  function automatic int cmax(int i);
    return (i == 0) ? ((1 << W_A) - 1) : ((1 << W_B) - 1);
  endfunction

  function automatic bit f_freeze();
    return mem_req && !mem_ready;
  endfunction

  function automatic bit f_load_use();
    return ex_mem_read && ex_reg_write && (ex_num_write != 5'd0) &&
           ((id_uses_rs && id_rs == ex_num_write) || (id_uses_rt && id_rt == ex_num_write));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_frozen[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
    end
  endfunction

  function automatic void model_eval();
    for (int i = 0; i < 2; i++) begin
      if (reset || m_state[i] == 2 || f_freeze()) begin
        exp_en[i] = 5'b00000; exp_fl[i] = 2'b00;
      end else if (branch_taken) begin
        exp_en[i] = 5'b11111; exp_fl[i] = 2'b11;
      end else if (f_load_use()) begin
        exp_en[i] = 5'b00111; exp_fl[i] = 2'b01;
      end else begin
        exp_en[i] = 5'b11111; exp_fl[i] = 2'b00;
      end
    end
  endfunction

  function automatic void model_tick();
    bit fz, lu;
    fz = f_freeze();
    lu = f_load_use();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_state[i] = 0; m_frozen[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
      end else if (m_state[i] != 2) begin
        if (cnt_clear) begin
          m_stall[i] = 0; m_flush[i] = 0;
        end else begin
          if (fz || (lu && !branch_taken)) m_stall[i] = (m_stall[i] < cmax(i)) ? m_stall[i] + 1 : cmax(i);
          if (branch_taken && !fz)         m_flush[i] = (m_flush[i] < cmax(i)) ? m_flush[i] + 1 : cmax(i);
        end
        if (fz) begin
          m_frozen[i] = m_frozen[i] + 1;
          m_state[i]  = (m_frozen[i] >= tmo(i)) ? 2 : 1;
        end else begin
          m_frozen[i] = 0;
          m_state[i]  = 0;
        end
      end
    end
  endfunction

  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_num_write = 5'd0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; cnt_clear = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_num_write = rd;
    id_rs = 5'd8; id_uses_rs = 1'b1;
  endtask

  task automatic step();
    @(posedge clock);
    model_tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    branch_taken = 1'b1;
    mem_req = 1'b1;
    mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs_en[i] !== 5'b00000 || obs_fl[i] !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_outputs[%0d]: got en=%b fl=%b want en=00000 fl=00", i, obs_en[i], obs_fl[i]);
      end
      vectors++;
      if (obs_state[i] !== 2'd0 || obs_err[i] !== 1'b0 || obs_stall[i] !== 16'd0 || obs_flush[i] !== 16'd0) begin
        miscompares++;
        $display("FAIL reset_state[%0d]: got st=%0d err=%b stall=%0d flush=%0d want 0 0 0 0",
                 i, obs_state[i], obs_err[i], obs_stall[i], obs_flush[i]);
      end
    end
    @(negedge clock);
    model_reset();
    reset = 1'b0;
    set_idle();
    #1;
    vectors++;
    if (obs_en[0] !== 5'b11111 || obs_fl[0] !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_release: got en=%b fl=%b want en=11111 fl=00", obs_en[0], obs_fl[0]);
    end
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(5'd8);
    #1;
    vectors++;
    if (obs_en[0] !== 5'b00111 || obs_fl[0] !== 2'b01) begin
      miscompares++;
      $display("FAIL load_use_bubble: got en=%b fl=%b want en=00111 fl=01", obs_en[0], obs_fl[0]);
    end
    step();
    set_idle();
    #1;
    vectors++;
    if (obs_stall[0] !== 16'd1 || obs_en[0] !== 5'b11111) begin
      miscompares++;
      $display("FAIL load_use_count: got stall=%0d en=%b want stall=1 en=11111", obs_stall[0], obs_en[0]);
    end
    set_load_use(5'd0);
    id_rs = 5'd0;
    #1;
    vectors++;
    if (obs_en[0] !== 5'b11111 || obs_fl[0] !== 2'b00) begin
      miscompares++;
      $display("FAIL load_use_r0: got en=%b fl=%b want en=11111 fl=00", obs_en[0], obs_fl[0]);
    end
    step();
    set_idle();
    #1;
    vectors++;
    if (obs_stall[0] !== 16'd1) begin
      miscompares++;
      $display("FAIL load_use_r0_count: got stall=%0d want 1", obs_stall[0]);
    end
  endtask

  task automatic test_branch_flush();
    do_reset();
    set_load_use(5'd8);
    branch_taken = 1'b1;
    #1;
    vectors++;
    if (obs_en[0] !== 5'b11111 || obs_fl[0] !== 2'b11) begin
      miscompares++;
      $display("FAIL branch_flush: got en=%b fl=%b want en=11111 fl=11", obs_en[0], obs_fl[0]);
    end
    step();
    set_idle();
    #1;
    vectors++;
    if (obs_flush[0] !== 16'd1 || obs_stall[0] !== 16'd0) begin
      miscompares++;
      $display("FAIL branch_count: got flush=%0d stall=%0d want flush=1 stall=0", obs_flush[0], obs_stall[0]);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1'b1;
    mem_ready = 1'b0;
    branch_taken = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      #1;
      vectors++;
      if (obs_en[0] !== 5'b00000 || obs_fl[0] !== 2'b00) begin
        miscompares++;
        $display("FAIL mem_wait_frozen cyc %0d: got en=%b fl=%b want en=00000 fl=00", k, obs_en[0], obs_fl[0]);
      end
      step();
      vectors++;
      if (obs_state[0] !== 2'd1) begin
        miscompares++;
        $display("FAIL mem_wait_state cyc %0d: got %0d want 1", k, obs_state[0]);
      end
    end
    mem_ready = 1'b1;
    #1;
    vectors++;
    if (obs_en[0] !== 5'b11111 || obs_fl[0] !== 2'b11) begin
      miscompares++;
      $display("FAIL mem_wait_release: got en=%b fl=%b want en=11111 fl=11", obs_en[0], obs_fl[0]);
    end
    step();
    set_idle();
    #1;
    vectors++;
    if (obs_state[0] !== 2'd0 || obs_stall[0] !== 16'd3 || obs_flush[0] !== 16'd1) begin
      miscompares++;
      $display("FAIL mem_wait_after: got st=%0d stall=%0d flush=%0d want 0 3 1",
               obs_state[0], obs_stall[0], obs_flush[0]);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1;
    mem_ready = 1'b0;
    for (int k = 1; k <= TO_B; k++) begin
      #1;
      vectors++;
      if (obs_en[1] !== 5'b00000) begin
        miscompares++;
        $display("FAIL timeout_frozen cyc %0d: got en=%b want 00000", k, obs_en[1]);
      end
      step();
      vectors++;
      if (obs_state[1] !== ((k < TO_B) ? 2'd1 : 2'd2) || obs_err[1] !== (k == TO_B)) begin
        miscompares++;
        $display("FAIL timeout_state cyc %0d: got st=%0d err=%b want st=%0d err=%b",
                 k, obs_state[1], obs_err[1], (k < TO_B) ? 1 : 2, (k == TO_B));
      end
    end
    mem_ready = 1'b1;
    #1;
    vectors++;
    if (obs_en[1] !== 5'b00000 || obs_fl[1] !== 2'b00 || obs_en[0] !== 5'b11111) begin
      miscompares++;
      $display("FAIL timeout_hold: got en_b=%b fl_b=%b en_a=%b want 00000 00 11111", obs_en[1], obs_fl[1], obs_en[0]);
    end
    step();
    vectors++;
    if (obs_state[1] !== 2'd2 || obs_err[1] !== 1'b1 || obs_state[0] !== 2'd0) begin
      miscompares++;
      $display("FAIL timeout_sticky: got st_b=%0d err_b=%b st_a=%0d want 2 1 0", obs_state[1], obs_err[1], obs_state[0]);
    end
    set_idle();
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (obs_state[1] !== 2'd0 || obs_err[1] !== 1'b0 || obs_en[1] !== 5'b00000) begin
      miscompares++;
      $display("FAIL async_reset: got st=%0d err=%b en=%b want 0 0 00000", obs_state[1], obs_err[1], obs_en[1]);
    end
    model_reset();
    #1 reset = 1'b0;
    step();
    #1;
    vectors++;
    if (obs_state[1] !== 2'd0 || obs_en[1] !== 5'b11111) begin
      miscompares++;
      $display("FAIL after_reset: got st=%0d en=%b want 0 11111", obs_state[1], obs_en[1]);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_use(5'd8);
    for (int k = 1; k <= 20; k++) begin
      step();
      vectors++;
      if (obs_stall[1] !== 16'((k < 15) ? k : 15)) begin
        miscompares++;
        $display("FAIL saturation cyc %0d: got %0d want %0d", k, obs_stall[1], (k < 15) ? k : 15);
      end
    end
    cnt_clear = 1'b1;
    step();
    set_idle();
    #1;
    vectors++;
    if (obs_stall[1] !== 16'd0 || obs_stall[0] !== 16'd0) begin
      miscompares++;
      $display("FAIL clear_priority: got b=%0d a=%0d want 0 0", obs_stall[1], obs_stall[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if (c % 250 == 0) do_reset();
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_uses_rs   = 1'($urandom_range(0, 1));
      id_uses_rt   = 1'($urandom_range(0, 1));
      ex_num_write = 5'($urandom_range(0, 3));
      ex_mem_read  = ($urandom_range(0, 99) < 60);
      ex_reg_write = ($urandom_range(0, 99) < 80);
      branch_taken = ($urandom_range(0, 99) < 20);
      mem_req      = ($urandom_range(0, 99) < 40);
      mem_ready    = ($urandom_range(0, 99) < 60);
      cnt_clear    = (m_state[0] != 2 && m_state[1] != 2) && ($urandom_range(0, 99) < 3);
      #1;
      model_eval();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs_en[i] !== exp_en[i] || obs_fl[i] !== exp_fl[i]) begin
          miscompares++;
          $display("FAIL rnd_ctrl[%0d] cyc %0d: got en=%b fl=%b want en=%b fl=%b",
                   i, c, obs_en[i], obs_fl[i], exp_en[i], exp_fl[i]);
        end
        vectors++;
        if (obs_state[i] !== 2'(m_state[i]) || obs_err[i] !== (m_state[i] == 2)) begin
          miscompares++;
          $display("FAIL rnd_state[%0d] cyc %0d: got st=%0d err=%b want st=%0d", i, c, obs_state[i], obs_err[i], m_state[i]);
        end
        vectors++;
        if (obs_stall[i] !== 16'(m_stall[i]) || obs_flush[i] !== 16'(m_flush[i])) begin
          miscompares++;
          $display("FAIL rnd_cnt[%0d] cyc %0d: got stall=%0d flush=%0d want %0d %0d",
                   i, c, obs_stall[i], obs_flush[i], m_stall[i], m_flush[i]);
        end
      end
      step();
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    set_idle();
    model_reset();
    test_reset();
    test_load_use();
    test_branch_flush();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
